seq_statemachine: RTL and testbench
===================================

SEQ_STATEMACHINE -- requirements
Module: seq_statemachine

Interface
REQ-001 The block SHALL have parameter HOLD_A, default 4, the number of consecutive sampled-high cycles of A needed to arm (legal range 2..2**CNT_W-1).
REQ-002 The block SHALL have parameter TIMEOUT, default 8, the maximum number of cycles in ARMED waiting for B (legal range 1..2**CNT_W-1).
REQ-003 The block SHALL have parameter MODE, default 0, where 0 gives a level output held while B is high and 1 gives a single-cycle output pulse.
REQ-004 The block SHALL have parameter CNT_W, default 4, the width of the internal qualification/timeout counter.
REQ-005 The block SHALL have parameter EV_W, default 8, the width of the saturating fire-event counter.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: the reset, which is asynchronous and active-high.
REQ-008 The block SHALL have port A, input, 1 bit: the arm request, sampled on clk.
REQ-009 The block SHALL have port B, input, 1 bit: the trigger, sampled on clk.
REQ-010 The block SHALL have port out, output, 1 bit: the fire indication.
REQ-011 The block SHALL have port stateOut, output, 2 bits: the current state encoding.
REQ-012 The block SHALL have port timeout, output, 1 bit: a one-cycle pulse when ARMED expires.
REQ-013 The block SHALL have port events, output, EV_W bits: the count of FIRE entries.

Function
REQ-014 The state encoding SHALL be IDLE=2'b00, ARMING=2'b01, ARMED=2'b10, FIRE=2'b11, and stateOut SHALL equal the state register directly.
REQ-015 In IDLE with A=1, the block SHALL set cnt=1 and go to ARMING; with A=0 it SHALL stay in IDLE with cnt=0.
REQ-016 In ARMING with A=0, the block SHALL return to IDLE with cnt=0.
REQ-017 In ARMING with A=1 and cnt+1==HOLD_A, the block SHALL go to ARMED with cnt=0; otherwise it SHALL increment cnt, so ARMED is entered at the HOLD_A-th consecutive A-high edge.
REQ-018 In ARMED, A SHALL be ignored; B=1 SHALL cause a transition to FIRE.
REQ-019 In ARMED with B=0 and cnt==TIMEOUT-1, the block SHALL go to IDLE and assert timeout for exactly the next cycle; otherwise it SHALL increment cnt.
REQ-020 If B=1 is sampled on the same edge as the timeout expiry, B SHALL take priority: the block goes to FIRE and timeout stays 0.
REQ-021 With MODE=0, FIRE SHALL persist while B=1 and return to IDLE on the first edge with B=0.
REQ-022 With MODE=1, FIRE SHALL last exactly one cycle and then go to IDLE regardless of B.
REQ-023 out SHALL be 1 if and only if the state is FIRE (Moore, registered; no combinational path from A or B).
REQ-024 events SHALL increment by 1 on each ARMED->FIRE transition and saturate at 2**EV_W-1 with no wrap.
REQ-025 After FIRE or a timeout, re-arming SHALL require a fresh HOLD_A qualification starting from IDLE.

Reset
REQ-026 While rst=1, the block SHALL immediately set state=IDLE, cnt=0, out=0, stateOut=2'b00, timeout=0, events=0.
REQ-027 Reset asserted mid-operation in any state SHALL abort that operation without producing an out or timeout pulse, and SHALL not increment events.
REQ-028 After rst deasserts, the first sampling edge SHALL evaluate from IDLE.

Structure
REQ-029 The state encoding constants and the state typedef SHALL reside in the shared package seq_statemachine_pkg.
REQ-030 The saturating event counter SHALL be a sub-module named sat_counter, parametrised by width, with increment and asynchronous active-high reset.
REQ-031 The FSM and cnt SHALL be implemented in one module with a single registered next-state process.

Verification (defaults, 40 ns clock unless stated)
REQ-032 Reset for 2 edges, A=1 for 6 edges then A=0, B=1 two edges later -> ARMED at the 4th A edge, FIRE on the B edge, out stays high while B=1, events=1.
REQ-033 A=1 for 3 edges, then A=0 -> ARMING then IDLE, ARMED never reached, out=0.
REQ-034 Arm the block, keep B=0 for 8 edges -> IDLE, timeout high for one cycle, events unchanged.
REQ-035 Arm the block, raise B on the 8th ARMED edge -> FIRE, timeout=0.
REQ-036 With MODE=1, arm and hold B=1 for 5 cycles -> out high for exactly 1 cycle, then IDLE.
REQ-037 With EV_W=2, fire 5 times then assert rst during ARMING -> events saturates at 3, then is 0 after reset and stateOut=00 asynchronously.

Source files
------------

// File: rtl/seq_statemachine_pkg.sv
// Shared state encoding for the arm/trigger sequencer.
package seq_statemachine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ARMING = 2'b01,
    ST_ARMED  = 2'b10,
    ST_FIRE   = 2'b11
  } state_t;

  localparam logic [1:0] ENC_IDLE   = 2'b00;
  localparam logic [1:0] ENC_ARMING = 2'b01;
  localparam logic [1:0] ENC_ARMED  = 2'b10;
  localparam logic [1:0] ENC_FIRE   = 2'b11;

endpackage

// File: rtl/seq_statemachine_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Count increment requests, sticking at the maximum value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_statemachine.sv
// Arm/trigger sequencer: A must be held HOLD_A cycles to arm, then B fires
// within TIMEOUT cycles or the block drops back to idle with a timeout pulse.
//
// state   | meaning
// IDLE    | waiting for A
// ARMING  | qualifying consecutive A-high cycles
// ARMED   | waiting for B, timeout counter running
// FIRE    | out asserted (level while B, or single pulse)
module seq_statemachine
  import seq_statemachine_pkg::*;
#(
  parameter int HOLD_A  = 4,
  parameter int TIMEOUT = 8,
  parameter int MODE    = 0,
  parameter int CNT_W   = 4,
  parameter int EV_W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            A,
  input  logic            B,
  output logic            out,
  output logic [1:0]      stateOut,
  output logic            timeout,
  output logic [EV_W-1:0] events
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_A - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             fire_inc;

  // State, shared qualification/timeout counter and registered timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state and counter decisions; B beats timeout expiry in ARMED.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    fire_inc  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (A) begin
          state_d = ST_ARMING;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      ST_ARMING: begin
        if (!A) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_ARMED;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_ARMED: begin
        if (B) begin
          state_d  = ST_FIRE;
          cnt_d    = '0;
          fire_inc = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FIRE: begin
        cnt_d = '0;
        if ((MODE != 0) || !B) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore outputs straight from registers.
  always_comb begin
    out      = (state_q == ST_FIRE);
    stateOut = state_q;
    timeout  = timeout_q;
  end

  sat_counter #(
    .W(EV_W)
  ) u_events (
    .clk  (clk),
    .rst  (rst),
    .inc  (fire_inc),
    .count(events)
  );

endmodule

// File: tb/tb_seq_statemachine.sv
// Directed bench: default-parameter instance plus a MODE=1 / EV_W=2 instance.
module tb_seq_statemachine;

  logic       clk;
  logic       rst0, a0, b0;
  logic       out0, to0;
  logic [1:0] st0;
  logic [7:0] ev0;
  logic       rst1, a1, b1;
  logic       out1, to1;
  logic [1:0] st1;
  logic [1:0] ev1;

  int errors = 0;
  int checks = 0;

  seq_statemachine dut0 (
    .clk(clk), .rst(rst0), .A(a0), .B(b0),
    .out(out0), .stateOut(st0), .timeout(to0), .events(ev0)
  );

  seq_statemachine #(.MODE(1), .EV_W(2)) dut1 (
    .clk(clk), .rst(rst1), .A(a1), .B(b1),
    .out(out1), .stateOut(st1), .timeout(to1), .events(ev1)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic arm0();
    a0 = 1'b1;
    repeat (4) tick();
    a0 = 1'b0;
  endtask

  task automatic arm1();
    a1 = 1'b1;
    repeat (4) tick();
    a1 = 1'b0;
  endtask

  initial begin
    rst0 = 1'b1; a0 = 1'b0; b0 = 1'b0;
    rst1 = 1'b1; a1 = 1'b0; b1 = 1'b0;
    repeat (2) tick();
    chk("rst_state", 32'(st0), 32'(2'b00));
    chk("rst_out", 32'(out0), 32'd0);
    chk("rst_timeout", 32'(to0), 32'd0);
    chk("rst_events", 32'(ev0), 32'd0);
    rst0 = 1'b0;
    rst1 = 1'b0;

    // A held 6 edges, B two edges after A drops
    a0 = 1'b1;
    tick();
    chk("arm_e1_arming", 32'(st0), 32'(2'b01));
    tick(); tick();
    chk("arm_e3_arming", 32'(st0), 32'(2'b01));
    tick();
    chk("arm_e4_armed", 32'(st0), 32'(2'b10));
    tick(); tick();
    chk("arm_a_ignored", 32'(st0), 32'(2'b10));
    a0 = 1'b0;
    tick(); tick();
    chk("armed_wait", 32'(st0), 32'(2'b10));
    chk("armed_out0", 32'(out0), 32'd0);
    b0 = 1'b1;
    tick();
    chk("fire_state", 32'(st0), 32'(2'b11));
    chk("fire_out", 32'(out0), 32'd1);
    chk("fire_events", 32'(ev0), 32'd1);
    tick(); tick();
    chk("fire_hold_out", 32'(out0), 32'd1);
    chk("fire_hold_ev", 32'(ev0), 32'd1);
    b0 = 1'b0;
    tick();
    chk("fire_exit_state", 32'(st0), 32'(2'b00));
    chk("fire_exit_out", 32'(out0), 32'd0);

    // Short A: never arms
    a0 = 1'b1;
    repeat (3) tick();
    chk("short_arming", 32'(st0), 32'(2'b01));
    a0 = 1'b0;
    tick();
    chk("short_idle", 32'(st0), 32'(2'b00));
    chk("short_out", 32'(out0), 32'd0);

    // Timeout after 8 ARMED edges
    arm0();
    chk("to_armed", 32'(st0), 32'(2'b10));
    repeat (7) tick();
    chk("to_e7_armed", 32'(st0), 32'(2'b10));
    chk("to_e7_pulse", 32'(to0), 32'd0);
    tick();
    chk("to_e8_idle", 32'(st0), 32'(2'b00));
    chk("to_e8_pulse", 32'(to0), 32'd1);
    chk("to_events", 32'(ev0), 32'd1);
    tick();
    chk("to_pulse_end", 32'(to0), 32'd0);

    // B on the expiry edge wins
    arm0();
    repeat (7) tick();
    b0 = 1'b1;
    tick();
    chk("prio_fire", 32'(st0), 32'(2'b11));
    chk("prio_no_to", 32'(to0), 32'd0);
    chk("prio_events", 32'(ev0), 32'd2);
    b0 = 1'b0;
    tick();
    chk("prio_idle", 32'(st0), 32'(2'b00));
    chk("prio_no_to2", 32'(to0), 32'd0);

    // Async reset during FIRE
    arm0();
    b0 = 1'b1;
    tick();
    chk("rfire_out", 32'(out0), 32'd1);
    #10 rst0 = 1'b1;
    #1;
    chk("rfire_state", 32'(st0), 32'(2'b00));
    chk("rfire_out0", 32'(out0), 32'd0);
    chk("rfire_ev0", 32'(ev0), 32'd0);
    b0 = 1'b0;
    tick();
    rst0 = 1'b0;
    tick();
    chk("rfire_after", 32'(st0), 32'(2'b00));

    // MODE=1: single-cycle pulse though B held 5 cycles
    arm1();
    chk("m1_armed", 32'(st1), 32'(2'b10));
    b1 = 1'b1;
    tick();
    chk("m1_fire", 32'(out1), 32'd1);
    chk("m1_ev", 32'(ev1), 32'd1);
    tick();
    chk("m1_pulse_end", 32'(out1), 32'd0);
    chk("m1_idle", 32'(st1), 32'(2'b00));
    repeat (3) tick();
    chk("m1_stay_idle", 32'(st1), 32'(2'b00));
    chk("m1_out_low", 32'(out1), 32'd0);
    b1 = 1'b0;

    // Four more fires: saturate at 3
    for (int i = 0; i < 4; i++) begin
      arm1();
      b1 = 1'b1;
      tick();
      b1 = 1'b0;
      tick();
    end
    chk("sat_events", 32'(ev1), 32'd3);

    // Reset during ARMING
    a1 = 1'b1;
    tick(); tick();
    chk("r_arming", 32'(st1), 32'(2'b01));
    #10 rst1 = 1'b1;
    #1;
    chk("r_state", 32'(st1), 32'(2'b00));
    chk("r_events", 32'(ev1), 32'd0);
    chk("r_timeout", 32'(to1), 32'd0);
    a1 = 1'b0;
    tick();
    rst1 = 1'b0;
    a1 = 1'b1;
    tick();
    chk("r_fresh_arming", 32'(st1), 32'(2'b01));
    a1 = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
